// File: rtl/sram_axi_pkg.sv
// Shared IDs, state encodings and fixed AXI field values for the SRAM-to-AXI bridge.
package sram_axi_pkg;
  localparam logic [3:0] ID_INST   = 4'd0;
  localparam logic [3:0] ID_DATA   = 4'd1;
  localparam logic [7:0] AXI_LEN   = 8'd0;
  localparam logic [1:0] AXI_BURST = 2'b01;
  localparam logic [1:0] AXI_LOCK  = 2'b00;
  localparam logic [3:0] AXI_CACHE = 4'b0000;
  localparam logic [2:0] AXI_PROT  = 3'b000;

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, RET} port_state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_INST, GNT_DATA} ar_grant_e;

  function automatic logic [2:0] axi_size(input logic [1:0] s);
    return {1'b0, s};
  endfunction
endpackage

// File: rtl/sram_axi_bridge_if.sv
// AXI3 master bus of the bridge; master = bridge side, slave = interconnect side.
interface sram_axi_bridge_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic [3:0]          arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [3:0]          rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  logic [3:0]          awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [1:0]          awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [3:0]          wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [3:0]          bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output wid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  wid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/sram_port_ctrl.sv
// One SRAM-side port: IDLE/ADDR/WAIT/RET FSM with request and return registers.
module sram_port_ctrl
  import sram_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit WR_EN  = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req,
  input  logic                wr,
  input  logic [1:0]          size,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   wdata,
  output logic                addr_ok,
  output logic                data_ok,
  output logic [DATA_W-1:0]   rdata,
  input  logic                addr_done,
  input  logic                resp_hit,
  input  logic [DATA_W-1:0]   resp_data,
  output port_state_e         state,
  output logic [ADDR_W-1:0]   req_addr,
  output logic [1:0]          req_size,
  output logic                req_wr,
  output logic [DATA_W/8-1:0] req_wstrb,
  output logic [DATA_W-1:0]   req_wdata
);
  port_state_e         state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                wr_q, wr_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      wstrb_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wr_d    = wr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    case (state_q)
      IDLE: begin
        addr_ok = req;
        if (req) begin
          addr_d  = addr;
          size_d  = size;
          // The fetch port instance drops the write fields so it can only read.
          wr_d    = WR_EN & wr;
          wstrb_d = WR_EN ? wstrb : '0;
          wdata_d = WR_EN ? wdata : '0;
          state_d = ADDR;
        end
      end
      ADDR: if (addr_done) state_d = WAIT;
      WAIT: begin
        if (resp_hit) begin
          if (!wr_q) rdata_d = resp_data;
          state_d = RET;
        end
      end
      RET: begin
        data_ok = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdata     = rdata_q;
  assign state     = state_q;
  assign req_addr  = addr_q;
  assign req_size  = size_q;
  assign req_wr    = wr_q;
  assign req_wstrb = wstrb_q;
  assign req_wdata = wdata_q;
endmodule

// File: rtl/sram_axi_bridge.sv
// Merges the fetch and data SRAM ports onto one AXI3 master: AR arbitration, AW/W/B for stores, R routing by ID.
module sram_axi_bridge
  import sram_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_sram_req,
  input  logic                inst_sram_wr,
  input  logic [1:0]          inst_sram_size,
  input  logic [ADDR_W-1:0]   inst_sram_addr,
  input  logic [DATA_W/8-1:0] inst_sram_wstrb,
  input  logic [DATA_W-1:0]   inst_sram_wdata,
  output logic                inst_sram_addr_ok,
  output logic                inst_sram_data_ok,
  output logic [DATA_W-1:0]   inst_sram_rdata,
  input  logic                data_sram_req,
  input  logic                data_sram_wr,
  input  logic [1:0]          data_sram_size,
  input  logic [ADDR_W-1:0]   data_sram_addr,
  input  logic [DATA_W/8-1:0] data_sram_wstrb,
  input  logic [DATA_W-1:0]   data_sram_wdata,
  output logic                data_sram_addr_ok,
  output logic                data_sram_data_ok,
  output logic [DATA_W-1:0]   data_sram_rdata,
  sram_axi_bridge_if.master   axi
);
  localparam int STRB_W = DATA_W / 8;

  port_state_e       inst_state, data_state;
  logic [ADDR_W-1:0] inst_addr, data_addr;
  logic [1:0]        inst_size, data_size;
  logic              inst_wr, data_wr;
  logic [STRB_W-1:0] inst_wstrb, data_wstrb;
  logic [DATA_W-1:0] inst_wdata, data_wdata;
  logic              inst_addr_done, data_addr_done, inst_hit, data_hit;
  logic              inst_ar_req, data_ar_req, data_w_req;
  ar_grant_e         grant_q, grant_d, ar_sel;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d, aw_hs, w_hs;
  logic              unused_ok;

  sram_port_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_EN(1'b0)) u_inst (
    .clk(clk), .resetn(resetn),
    .req(inst_sram_req), .wr(inst_sram_wr), .size(inst_sram_size), .addr(inst_sram_addr),
    .wstrb(inst_sram_wstrb), .wdata(inst_sram_wdata),
    .addr_ok(inst_sram_addr_ok), .data_ok(inst_sram_data_ok), .rdata(inst_sram_rdata),
    .addr_done(inst_addr_done), .resp_hit(inst_hit), .resp_data(axi.rdata),
    .state(inst_state), .req_addr(inst_addr), .req_size(inst_size), .req_wr(inst_wr),
    .req_wstrb(inst_wstrb), .req_wdata(inst_wdata)
  );

  sram_port_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_EN(1'b1)) u_data (
    .clk(clk), .resetn(resetn),
    .req(data_sram_req), .wr(data_sram_wr), .size(data_sram_size), .addr(data_sram_addr),
    .wstrb(data_sram_wstrb), .wdata(data_sram_wdata),
    .addr_ok(data_sram_addr_ok), .data_ok(data_sram_data_ok), .rdata(data_sram_rdata),
    .addr_done(data_addr_done), .resp_hit(data_hit), .resp_data(axi.rdata),
    .state(data_state), .req_addr(data_addr), .req_size(data_size), .req_wr(data_wr),
    .req_wstrb(data_wstrb), .req_wdata(data_wdata)
  );

  assign inst_ar_req = (inst_state == ADDR);
  assign data_ar_req = (data_state == ADDR) && !data_wr;
  assign data_w_req  = (data_state == ADDR) && data_wr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      grant_q   <= GNT_NONE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      grant_q   <= grant_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // A stalled AR keeps its source locked so the address phase cannot change under it.
  always_comb begin
    ar_sel = GNT_NONE;
    if (grant_q != GNT_NONE) ar_sel = grant_q;
    else if (data_ar_req)    ar_sel = GNT_DATA;
    else if (inst_ar_req)    ar_sel = GNT_INST;
    axi.arvalid = (ar_sel != GNT_NONE);
    axi.arid    = '0;
    axi.araddr  = '0;
    axi.arsize  = '0;
    case (ar_sel)
      GNT_INST: begin
        axi.arid   = ID_INST;
        axi.araddr = inst_addr;
        axi.arsize = axi_size(inst_size);
      end
      GNT_DATA: begin
        axi.arid   = ID_DATA;
        axi.araddr = data_addr;
        axi.arsize = axi_size(data_size);
      end
      default: ;
    endcase
    grant_d = (axi.arvalid && !axi.arready) ? ar_sel : GNT_NONE;
  end

  assign inst_addr_done = (ar_sel == GNT_INST) && axi.arready;

  // AW and W complete independently; the store leaves ADDR once both have.
  assign axi.awvalid = data_w_req && !aw_done_q;
  assign axi.wvalid  = data_w_req && !w_done_q;
  assign aw_hs       = aw_done_q || (axi.awvalid && axi.awready);
  assign w_hs        = w_done_q  || (axi.wvalid  && axi.wready);
  assign data_addr_done = data_w_req ? (aw_hs && w_hs) : ((ar_sel == GNT_DATA) && axi.arready);

  always_comb begin
    aw_done_d = 1'b0;
    w_done_d  = 1'b0;
    if (data_w_req && !(aw_hs && w_hs)) begin
      aw_done_d = aw_hs;
      w_done_d  = w_hs;
    end
  end

  assign axi.awid   = ID_DATA;
  assign axi.awaddr = data_w_req ? data_addr : '0;
  assign axi.awsize = data_w_req ? axi_size(data_size) : '0;
  assign axi.wid    = ID_DATA;
  assign axi.wdata  = data_w_req ? data_wdata : '0;
  assign axi.wstrb  = data_w_req ? data_wstrb : '0;
  assign axi.wlast  = 1'b1;

  assign axi.arlen   = AXI_LEN;
  assign axi.arburst = AXI_BURST;
  assign axi.arlock  = AXI_LOCK;
  assign axi.arcache = AXI_CACHE;
  assign axi.arprot  = AXI_PROT;
  assign axi.awlen   = AXI_LEN;
  assign axi.awburst = AXI_BURST;
  assign axi.awlock  = AXI_LOCK;
  assign axi.awcache = AXI_CACHE;
  assign axi.awprot  = AXI_PROT;
  assign axi.rready  = 1'b1;
  assign axi.bready  = 1'b1;

  // Beats with a foreign ID or for a port not waiting are accepted and dropped.
  assign inst_hit = axi.rvalid && (axi.rid == ID_INST) && (inst_state == WAIT);
  assign data_hit = (data_state == WAIT) &&
                    (data_wr ? (axi.bvalid && axi.bid == ID_DATA)
                             : (axi.rvalid && axi.rid == ID_DATA));

  assign unused_ok = ^{inst_wr, inst_wstrb, inst_wdata, axi.rresp, axi.bresp, axi.rlast};
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed scenarios for the SRAM-to-AXI bridge with hand-computed expectations.
module tb_sram_axi_bridge;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic [3:0]  inst_wstrb;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;

  int tests = 0;
  int fails = 0;

  sram_axi_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sram_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_req), .inst_sram_wr(inst_wr), .inst_sram_size(inst_size),
    .inst_sram_addr(inst_addr), .inst_sram_wstrb(inst_wstrb), .inst_sram_wdata(inst_wdata),
    .inst_sram_addr_ok(inst_addr_ok), .inst_sram_data_ok(inst_data_ok), .inst_sram_rdata(inst_rdata),
    .data_sram_req(data_req), .data_sram_wr(data_wr), .data_sram_size(data_size),
    .data_sram_addr(data_addr), .data_sram_wstrb(data_wstrb), .data_sram_wdata(data_wdata),
    .data_sram_addr_ok(data_addr_ok), .data_sram_data_ok(data_data_ok), .data_sram_rdata(data_rdata),
    .axi(bus)
  );

  // Inputs change on the falling edge; checks run 1ns later, away from the rising edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_wr = 1; inst_size = 2'd2; inst_addr = 0; inst_wstrb = 4'hf; inst_wdata = 32'hffff_ffff;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 1; bus.rvalid = 0;
    bus.awready = 0; bus.wready = 0; bus.bid = 0; bus.bresp = 0; bus.bvalid = 0;
  endtask

  task automatic test_reset();
    resetn = 0;
    clear_inputs();
    repeat (2) cyc();
    #1;
    tests++;
    if ({bus.arvalid, bus.awvalid, bus.wvalid, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 7'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b exp 0000000",
        {bus.arvalid, bus.awvalid, bus.wvalid, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok});
    end
    tests++;
    if ({inst_rdata, data_rdata, bus.araddr, bus.awaddr, bus.wdata} !== 160'b0) begin
      fails++; $display("FAIL reset_buses: got %h %h %h %h %h exp all 0",
        inst_rdata, data_rdata, bus.araddr, bus.awaddr, bus.wdata);
    end
    tests++;
    if ({bus.rready, bus.bready} !== 2'b11) begin
      fails++; $display("FAIL reset_ready: got %b exp 11", {bus.rready, bus.bready});
    end
    cyc(); resetn = 1;
  endtask

  task automatic test_single_fetch();
    cyc(); inst_req = 1; inst_addr = 32'h1c00_0000; bus.arready = 1; #1;
    tests++;
    if ({inst_addr_ok, bus.arvalid} !== 2'b10) begin
      fails++; $display("FAIL fetch_T addr_ok/arvalid: got %b exp 10", {inst_addr_ok, bus.arvalid});
    end
    cyc(); inst_req = 0; #1;
    tests++;
    if ({bus.arvalid, bus.arid, bus.araddr, bus.arsize} !== {1'b1, 4'd0, 32'h1c00_0000, 3'd2}) begin
      fails++; $display("FAIL fetch_T1 ar: got %b %h %h %h exp 1 0 1c000000 2",
        bus.arvalid, bus.arid, bus.araddr, bus.arsize);
    end
    cyc(); bus.rvalid = 1; bus.rid = 4'd0; bus.rdata = 32'h0280_0000; #1;
    tests++;
    if ({bus.arvalid, inst_data_ok} !== 2'b00) begin
      fails++; $display("FAIL fetch_T2 arvalid/data_ok: got %b exp 00", {bus.arvalid, inst_data_ok});
    end
    cyc(); bus.rvalid = 0; bus.rdata = 0; #1;
    tests++;
    if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h0280_0000}) begin
      fails++; $display("FAIL fetch_T3 data_ok/rdata: got %b %h exp 1 02800000", inst_data_ok, inst_rdata);
    end
    cyc(); #1;
    tests++;
    if ({inst_data_ok, inst_rdata} !== {1'b0, 32'h0280_0000}) begin
      fails++; $display("FAIL fetch_T4 one_cycle: got %b %h exp 0 02800000", inst_data_ok, inst_rdata);
    end
  endtask

  task automatic test_simultaneous();
    cyc(); inst_req = 1; inst_addr = 32'h100; data_req = 1; data_wr = 0; data_addr = 32'h200; #1;
    tests++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b11) begin
      fails++; $display("FAIL simul_T addr_ok: got %b exp 11", {inst_addr_ok, data_addr_ok});
    end
    cyc(); inst_req = 0; data_req = 0; #1;
    tests++;
    if ({bus.arvalid, bus.arid, bus.araddr} !== {1'b1, 4'd1, 32'h200}) begin
      fails++; $display("FAIL simul_T1 data_ar_first: got %b %h %h exp 1 1 200", bus.arvalid, bus.arid, bus.araddr);
    end
    cyc(); #1;
    tests++;
    if ({bus.arvalid, bus.arid, bus.araddr} !== {1'b1, 4'd0, 32'h100}) begin
      fails++; $display("FAIL simul_T2 inst_ar_second: got %b %h %h exp 1 0 100", bus.arvalid, bus.arid, bus.araddr);
    end
    cyc(); bus.rvalid = 1; bus.rid = 4'd0; bus.rdata = 32'haaaa_0000; #1;
    cyc(); bus.rid = 4'd1; bus.rdata = 32'hbbbb_1111; #1;
    tests++;
    if ({inst_data_ok, inst_rdata, data_data_ok} !== {1'b1, 32'haaaa_0000, 1'b0}) begin
      fails++; $display("FAIL simul_inst_ret: got %b %h %b exp 1 aaaa0000 0", inst_data_ok, inst_rdata, data_data_ok);
    end
    cyc(); bus.rvalid = 0; bus.rdata = 0; #1;
    tests++;
    if ({data_data_ok, data_rdata, inst_data_ok} !== {1'b1, 32'hbbbb_1111, 1'b0}) begin
      fails++; $display("FAIL simul_data_ret: got %b %h %b exp 1 bbbb1111 0", data_data_ok, data_rdata, inst_data_ok);
    end
  endtask

  task automatic test_store();
    cyc(); bus.arready = 0; data_req = 1; data_wr = 1; data_addr = 32'h1c00_1000;
    data_wstrb = 4'b0011; data_wdata = 32'h1234_5678; #1;
    tests++;
    if (data_addr_ok !== 1'b1) begin
      fails++; $display("FAIL store_T addr_ok: got %b exp 1", data_addr_ok);
    end
    cyc(); data_req = 0; data_wr = 0; bus.awready = 1; #1;
    tests++;
    if ({bus.awvalid, bus.wvalid, bus.awid, bus.wid, bus.awaddr, bus.wstrb, bus.wdata, bus.wlast, bus.arvalid} !==
        {2'b11, 4'd1, 4'd1, 32'h1c00_1000, 4'b0011, 32'h1234_5678, 1'b1, 1'b0}) begin
      fails++; $display("FAIL store_T1 aw/w: got %b%b %h %h %h %b %h %b %b", bus.awvalid, bus.wvalid,
        bus.awid, bus.wid, bus.awaddr, bus.wstrb, bus.wdata, bus.wlast, bus.arvalid);
    end
    cyc(); bus.awready = 0; #1;
    tests++;
    if ({bus.awvalid, bus.wvalid} !== 2'b01) begin
      fails++; $display("FAIL store_T2 aw_dropped: got %b exp 01", {bus.awvalid, bus.wvalid});
    end
    cyc(); bus.wready = 1; #1;
    tests++;
    if ({bus.awvalid, bus.wvalid, bus.wdata} !== {2'b01, 32'h1234_5678}) begin
      fails++; $display("FAIL store_T3 w_held: got %b %h exp 01 12345678", {bus.awvalid, bus.wvalid}, bus.wdata);
    end
    cyc(); bus.wready = 0; bus.bvalid = 1; bus.bid = 4'd1; #1;
    tests++;
    if ({bus.wvalid, data_data_ok} !== 2'b00) begin
      fails++; $display("FAIL store_T4 wvalid/data_ok: got %b exp 00", {bus.wvalid, data_data_ok});
    end
    cyc(); bus.bvalid = 0; #1;
    tests++;
    if ({data_data_ok, data_rdata} !== {1'b1, 32'hbbbb_1111}) begin
      fails++; $display("FAIL store_T5 data_ok/rdata: got %b %h exp 1 bbbb1111", data_data_ok, data_rdata);
    end
  endtask

  task automatic test_ar_stall();
    cyc(); inst_req = 1; inst_addr = 32'h1c00_0040; bus.arready = 0; #1;
    cyc(); inst_req = 0; data_req = 1; data_wr = 0; data_addr = 32'h300; #1;
    tests++;
    if (data_addr_ok !== 1'b1) begin
      fails++; $display("FAIL stall data_addr_ok: got %b exp 1", data_addr_ok);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin cyc(); data_req = 0; end
      if (i == 4) bus.arready = 1;
      #1;
      tests++;
      if ({bus.arvalid, bus.arid, bus.araddr} !== {1'b1, 4'd0, 32'h1c00_0040}) begin
        fails++; $display("FAIL stall_hold cycle %0d: got %b %h %h exp 1 0 1c000040", i, bus.arvalid, bus.arid, bus.araddr);
      end
    end
    cyc(); #1;
    tests++;
    if ({bus.arvalid, bus.arid, bus.araddr} !== {1'b1, 4'd1, 32'h300}) begin
      fails++; $display("FAIL stall_then_data: got %b %h %h exp 1 1 300", bus.arvalid, bus.arid, bus.araddr);
    end
  endtask

  task automatic test_bad_id();
    cyc(); bus.arready = 0; bus.rvalid = 1; bus.rid = 4'd5; bus.rdata = 32'hdead_beef; #1;
    tests++;
    if (bus.arvalid !== 1'b0) begin
      fails++; $display("FAIL badid arvalid: got %b exp 0", bus.arvalid);
    end
    cyc(); bus.rvalid = 0; #1;
    tests++;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      fails++; $display("FAIL badid dropped: got %b exp 00", {inst_data_ok, data_data_ok});
    end
    cyc(); bus.rvalid = 1; bus.rid = 4'd1; bus.rdata = 32'h0000_c0de; #1;
    cyc(); bus.rid = 4'd0; bus.rdata = 32'h1111_2222; #1;
    tests++;
    if ({data_data_ok, data_rdata, inst_data_ok} !== {1'b1, 32'h0000_c0de, 1'b0}) begin
      fails++; $display("FAIL badid data_ret: got %b %h %b exp 1 0000c0de 0", data_data_ok, data_rdata, inst_data_ok);
    end
    cyc(); bus.rvalid = 0; #1;
    tests++;
    if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h1111_2222}) begin
      fails++; $display("FAIL badid inst_ret: got %b %h exp 1 11112222", inst_data_ok, inst_rdata);
    end
  endtask

  task automatic test_reset_mid();
    cyc(); data_req = 1; data_wr = 0; data_addr = 32'h400; bus.arready = 1; #1;
    cyc(); data_req = 0; #1;
    cyc(); resetn = 0; #1;
    cyc(); resetn = 1; bus.rvalid = 1; bus.rid = 4'd1; bus.rdata = 32'h9999_9999; #1;
    tests++;
    if ({bus.arvalid, bus.awvalid, bus.wvalid, inst_data_ok, data_data_ok, data_addr_ok} !== 6'b0) begin
      fails++; $display("FAIL midreset ctrl: got %b exp 000000",
        {bus.arvalid, bus.awvalid, bus.wvalid, inst_data_ok, data_data_ok, data_addr_ok});
    end
    tests++;
    if ({data_rdata, inst_rdata, bus.araddr} !== 96'b0) begin
      fails++; $display("FAIL midreset buses: got %h %h %h exp 0", data_rdata, inst_rdata, bus.araddr);
    end
    cyc(); bus.rvalid = 0; data_req = 1; data_addr = 32'h500; #1;
    tests++;
    if ({data_addr_ok, data_data_ok} !== 2'b10) begin
      fails++; $display("FAIL midreset next_req: got %b exp 10", {data_addr_ok, data_data_ok});
    end
    cyc(); data_req = 0; #1;
    tests++;
    if ({bus.arvalid, bus.arid, bus.araddr} !== {1'b1, 4'd1, 32'h500}) begin
      fails++; $display("FAIL midreset ar: got %b %h %h exp 1 1 500", bus.arvalid, bus.arid, bus.araddr);
    end
    cyc(); bus.rvalid = 1; bus.rid = 4'd1; bus.rdata = 32'h5555_aaaa; #1;
    cyc(); bus.rvalid = 0; #1;
    tests++;
    if ({data_data_ok, data_rdata} !== {1'b1, 32'h5555_aaaa}) begin
      fails++; $display("FAIL midreset ret: got %b %h exp 1 5555aaaa", data_data_ok, data_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_store();
    test_ar_stall();
    test_bad_id();
    test_reset_mid();
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
